// File: rtl/ram_stream_dma.sv
// Sample-to-RAM DMA streamer: buffers scanner samples in a FIFO, splits each
// into RAM_WORD beats and writes them into a ring buffer through a DMA port.
module ram_stream_dma #(
  parameter int unsigned DAT_WID    = 24,
  parameter int unsigned RAM_WORD   = 16,
  parameter int unsigned RAM_WID    = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter bit          SIGN_EXT   = 1'b1,
  parameter int unsigned CMD_WID    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RAM_WID-1:0]  cmd_data,
  input  logic [CMD_WID-1:0]  cmd,
  input  logic                cmd_active,
  output logic                cmd_finished,
  output logic [RAM_WID-1:0]  cmd_data_out,
  input  logic [DAT_WID-1:0]  data,
  input  logic                data_commit,
  output logic                finished,
  output logic                stopped,
  output logic [RAM_WORD-1:0] word,
  output logic [RAM_WID-1:0]  addr,
  output logic                write,
  input  logic                valid
);

  localparam int unsigned BEATS  = (DAT_WID + RAM_WORD - 1) / RAM_WORD;
  localparam int unsigned PAD_W  = BEATS * RAM_WORD;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [RAM_WID-1:0] Step     = RAM_WID'(RAM_WORD / 8);
  localparam logic [PTR_W:0]     FullCnt  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [BEAT_W-1:0]  LastBeat = BEAT_W'(BEATS - 1);

  localparam logic [CMD_WID-1:0] CmdWriteLoc = CMD_WID'(0);
  localparam logic [CMD_WID-1:0] CmdWriteLen = CMD_WID'(1);
  localparam logic [CMD_WID-1:0] CmdReadPtr  = CMD_WID'(2);
  localparam logic [CMD_WID-1:0] CmdReadOvf  = CMD_WID'(3);
  localparam logic [CMD_WID-1:0] CmdReadFill = CMD_WID'(4);
  localparam logic [CMD_WID-1:0] CmdSetMode  = CMD_WID'(5);
  localparam logic [CMD_WID-1:0] CmdClear    = CMD_WID'(6);

  typedef enum logic [2:0] {StIdle, StPop, StFetch, StBeat, StGap} state_e;

  state_e state_q, state_d;

  logic [DAT_WID-1:0] mem [FIFO_DEPTH];
  logic [DAT_WID-1:0] rd_data_q;
  logic [PTR_W:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fill;

  logic [PAD_W-1:0]   sample_q, sample_d, sample_ext;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic               write_q, write_d;
  logic               fin_q, fin_d;
  logic               cmd_fin_q, cmd_fin_d;
  logic               stopped_q, stopped_d;
  logic               stop_mode_q, stop_mode_d;
  logic [RAM_WID-1:0] loc_start_q, loc_start_d, loc_len_q, loc_len_d;
  logic [RAM_WID-1:0] loc_off_q, loc_off_d, ovf_q, ovf_d, cmd_out_q, cmd_out_d;

  logic               full, empty, pop, push, push_req;
  logic               cmd_req, cmd_is_cfg, cmd_exec, clear_exec;
  logic [RAM_WID-1:0] off_step;
  logic               wrap_hit;

  assign fill     = wr_ptr_q - rd_ptr_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (fill == FullCnt);
  assign pop      = (state_q == StPop);
  assign push_req = data_commit && !fin_q;

  // Only config writes would move addr under a pending write, so only they wait;
  // CLEAR drops write on the same edge and may therefore act at once.
  assign cmd_req    = cmd_active && !cmd_fin_q;
  assign cmd_is_cfg = (cmd == CmdWriteLoc) || (cmd == CmdWriteLen);
  assign cmd_exec   = cmd_req && !(cmd_is_cfg && write_q);
  assign clear_exec = cmd_exec && (cmd == CmdClear);

  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign push = push_req && (!full || pop) && !clear_exec;

  assign off_step = loc_off_q + Step;
  assign wrap_hit = (loc_len_q != '0) && (off_step >= loc_len_q);

  assign addr         = loc_start_q + loc_off_q;
  assign write        = write_q;
  assign finished     = fin_q;
  assign cmd_finished = cmd_fin_q;
  assign cmd_data_out = cmd_out_q;
  assign stopped      = stopped_q;

  // Pad the popped sample to whole beats, sign- or zero-filled.
  always_comb begin
    sample_ext = {PAD_W{SIGN_EXT & rd_data_q[DAT_WID-1]}};
    sample_ext[DAT_WID-1:0] = rd_data_q;
  end

  // Select the current beat of the latched sample.
  always_comb begin
    word = '0;
    for (int b = 0; b < int'(BEATS); b++) begin
      if (beat_q == BEAT_W'(b)) word = sample_q[b*RAM_WORD +: RAM_WORD];
    end
  end

  // FIFO storage and registered read port.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[PTR_W-1:0]] <= data;
    if (pop) rd_data_q <= mem[rd_ptr_q[PTR_W-1:0]];
  end

  // Next-state for drain FSM, handshakes, FIFO pointers and command decode.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q + (PTR_W + 1)'(push);
    rd_ptr_d    = rd_ptr_q + (PTR_W + 1)'(pop);
    sample_d    = sample_q;
    beat_d      = beat_q;
    write_d     = write_q;
    fin_d       = fin_q;
    cmd_fin_d   = cmd_fin_q;
    stopped_d   = stopped_q;
    stop_mode_d = stop_mode_q;
    loc_start_d = loc_start_q;
    loc_len_d   = loc_len_q;
    loc_off_d   = loc_off_q;
    ovf_d       = ovf_q;
    cmd_out_d   = cmd_out_q;

    if (push_req) begin
      fin_d = 1'b1;
      if (full && !pop && (ovf_q != '1)) ovf_d = ovf_q + RAM_WID'(1);
    end else if (fin_q && !data_commit) begin
      fin_d = 1'b0;
    end

    unique case (state_q)
      StIdle: if (!empty && !stopped_q) state_d = StPop;
      StPop:  state_d = StFetch;
      StFetch: begin
        sample_d = sample_ext;
        beat_d   = '0;
        write_d  = 1'b1;
        state_d  = StBeat;
      end
      StBeat: begin
        if (valid) begin
          write_d = 1'b0;
          if (wrap_hit) begin
            loc_off_d = '0;
            if (stop_mode_q) stopped_d = 1'b1;
          end else begin
            loc_off_d = off_step;
          end
          if (beat_q == LastBeat) begin
            state_d = StIdle;
          end else begin
            beat_d  = beat_q + BEAT_W'(1);
            state_d = StGap;
          end
        end
      end
      StGap: begin
        write_d = 1'b1;
        state_d = StBeat;
      end
      default: state_d = StIdle;
    endcase

    if (cmd_exec) begin
      cmd_fin_d = 1'b1;
      case (cmd)
        CmdWriteLoc: begin
          loc_start_d = cmd_data;
          loc_off_d   = '0;
          stopped_d   = 1'b0;
        end
        CmdWriteLen: begin
          loc_len_d = cmd_data;
          loc_off_d = '0;
          stopped_d = 1'b0;
        end
        CmdReadPtr:  cmd_out_d = addr;
        CmdReadOvf:  cmd_out_d = ovf_q;
        CmdReadFill: cmd_out_d = RAM_WID'(fill);
        CmdSetMode:  stop_mode_d = cmd_data[0];
        CmdClear: begin
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          loc_off_d = '0;
          ovf_d     = '0;
          stopped_d = 1'b0;
          write_d   = 1'b0;
          beat_d    = '0;
          state_d   = StIdle;
        end
        default: ;
      endcase
    end else if (cmd_fin_q && !cmd_active) begin
      cmd_fin_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      sample_q    <= '0;
      beat_q      <= '0;
      write_q     <= 1'b0;
      fin_q       <= 1'b0;
      cmd_fin_q   <= 1'b0;
      stopped_q   <= 1'b0;
      stop_mode_q <= 1'b0;
      loc_start_q <= '0;
      loc_len_q   <= '0;
      loc_off_q   <= '0;
      ovf_q       <= '0;
      cmd_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      sample_q    <= sample_d;
      beat_q      <= beat_d;
      write_q     <= write_d;
      fin_q       <= fin_d;
      cmd_fin_q   <= cmd_fin_d;
      stopped_q   <= stopped_d;
      stop_mode_q <= stop_mode_d;
      loc_start_q <= loc_start_d;
      loc_len_q   <= loc_len_d;
      loc_off_q   <= loc_off_d;
      ovf_q       <= ovf_d;
      cmd_out_q   <= cmd_out_d;
    end
  end

endmodule

// File: tb/tb_ram_stream_dma.sv
// Self-checking bench for ram_stream_dma: table vectors, corner sequences and a
// randomized stream checked against a ring-buffer reference model.
module tb_ram_stream_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] cmd_data = '0;
  logic [2:0]  cmd = '0;
  logic        cmd_active = 1'b0;
  logic        cmd_finished;
  logic [31:0] cmd_data_out;
  logic [23:0] data = '0;
  logic        data_commit = 1'b0;
  logic        finished, stopped;
  logic [15:0] word;
  logic [31:0] addr;
  logic        write;
  logic        valid = 1'b0;

  // Second instance: 40-bit samples, zero-filled top beat, valid always high.
  logic [39:0] w_data = '0;
  logic        w_commit = 1'b0;
  logic        w_finished, w_stopped, w_write, w_cmd_finished;
  logic [15:0] w_word;
  logic [31:0] w_addr, w_cmd_data_out;
  logic        w_valid = 1'b1;

  int checks = 0;
  int errors = 0;
  int valid_mode = 0;
  int cyc = 0;
  logic [47:0] log_q[$];
  logic [47:0] log2_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_stream_dma #(.DAT_WID(24), .RAM_WORD(16), .RAM_WID(32), .FIFO_DEPTH(16),
                   .SIGN_EXT(1'b1), .CMD_WID(3)) dut (
    .clk(clk), .rst(rst), .cmd_data(cmd_data), .cmd(cmd), .cmd_active(cmd_active),
    .cmd_finished(cmd_finished), .cmd_data_out(cmd_data_out), .data(data),
    .data_commit(data_commit), .finished(finished), .stopped(stopped), .word(word),
    .addr(addr), .write(write), .valid(valid)
  );

  ram_stream_dma #(.DAT_WID(40), .RAM_WORD(16), .RAM_WID(32), .FIFO_DEPTH(16),
                   .SIGN_EXT(1'b0), .CMD_WID(3)) dut40 (
    .clk(clk), .rst(rst), .cmd_data(32'h0), .cmd(3'h0), .cmd_active(1'b0),
    .cmd_finished(w_cmd_finished), .cmd_data_out(w_cmd_data_out), .data(w_data),
    .data_commit(w_commit), .finished(w_finished), .stopped(w_stopped), .word(w_word),
    .addr(w_addr), .write(w_write), .valid(w_valid)
  );

  // Record every accepted DMA write, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst && write && valid) log_q.push_back({addr, word});
    if (rst && w_write && w_valid) log2_q.push_back({w_addr, w_word});
  end

  // valid driver: 0 = low, 1 = high, else random.
  initial forever begin
    @(posedge clk);
    #2;
    case (valid_mode)
      0: valid = 1'b0;
      1: valid = 1'b1;
      default: valid = 1'($urandom_range(0, 1));
    endcase
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [2:0] c, input logic [31:0] d, output logic [31:0] res);
    int n;
    cmd = c; cmd_data = d; cmd_active = 1'b1; n = 0;
    do begin tick(); n++; end while (!cmd_finished && n < 200);
    check("cmd_ack", cmd_finished, 1);
    res = cmd_data_out;
    cmd_active = 1'b0; n = 0;
    do begin tick(); n++; end while (cmd_finished && n < 200);
    check("cmd_ack_release", cmd_finished, 0);
  endtask

  task automatic push(input logic [23:0] s);
    int n;
    data = s; data_commit = 1'b1; n = 0;
    do begin tick(); n++; end while (!finished && n < 50);
    check("push_ack", finished, 1);
    data_commit = 1'b0; n = 0;
    do begin tick(); n++; end while (finished && n < 50);
    check("push_ack_release", finished, 0);
  endtask

  task automatic wait_writes(input int cnt, input int budget);
    int n = 0;
    while (log_q.size() < cnt && n < budget) begin tick(); n++; end
    check("write_count", log_q.size(), cnt);
  endtask

  task automatic wait_write_high(input string name);
    int n = 0;
    while (write !== 1'b1 && n < 200) begin tick(); n++; end
    check(name, write, 1);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_a"}, {cmd_finished, finished, stopped, write, word, addr}, 0);
    check({name, "_b"}, cmd_data_out, 0);
  endtask

  typedef struct {
    logic [23:0] sample;
    logic [15:0] w0;
    logic [15:0] w1;
  } vec_t;

  vec_t vecs[6];
  logic [31:0] r;

  initial begin
    int n, t0;
    logic [31:0] start, len, off_m;
    logic [31:0] padded;
    logic [23:0] rs[$];

    vecs[0] = '{24'h800001, 16'h0001, 16'hFF80};
    vecs[1] = '{24'h7FFFFF, 16'hFFFF, 16'h007F};
    vecs[2] = '{24'hFFFFFF, 16'hFFFF, 16'hFFFF};
    vecs[3] = '{24'h000000, 16'h0000, 16'h0000};
    vecs[4] = '{24'h123456, 16'h3456, 16'h0012};
    vecs[5] = '{24'hABCDEF, 16'hCDEF, 16'hFFAB};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("in_reset");
    rst = 1'b1;
    tick();
    check_outputs_zero("after_reset");

    // 40-bit, zero-filled instance: three beats per sample.
    begin
      logic [39:0] s40[2];
      logic [15:0] e40[6];
      s40[0] = 40'h12_3456_789A;
      s40[1] = 40'hFF_FFFF_FFFF;
      e40[0] = 16'h789A; e40[1] = 16'h3456; e40[2] = 16'h0012;
      e40[3] = 16'hFFFF; e40[4] = 16'hFFFF; e40[5] = 16'h00FF;
      for (int i = 0; i < 2; i++) begin
        w_data = s40[i]; w_commit = 1'b1; n = 0;
        do begin tick(); n++; end while (!w_finished && n < 50);
        check("w40_ack", w_finished, 1);
        w_commit = 1'b0; n = 0;
        do begin tick(); n++; end while (w_finished && n < 50);
      end
      n = 0;
      while (log2_q.size() < 6 && n < 200) begin tick(); n++; end
      check("w40_count", log2_q.size(), 6);
      for (int k = 0; k < 6 && k < log2_q.size(); k++)
        check("w40_beat", log2_q[k], {32'(2 * k), e40[k]});
    end

    // Table-driven padding vectors at 0x1000, len 64.
    valid_mode = 1;
    do_cmd(3'd0, 32'h1000, r);
    do_cmd(3'd1, 32'd64, r);
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].sample);
      wait_writes(2 * (i + 1), 100);
      if (log_q.size() >= 2 * (i + 1)) begin
        check("vec_w0", log_q[2*i],   {32'h1000 + 32'(4 * i), vecs[i].w0});
        check("vec_w1", log_q[2*i+1], {32'h1002 + 32'(4 * i), vecs[i].w1});
      end
    end

    // Wrap mode, len 8: offsets 0,2,4,6,0,2.
    log_q.delete();
    do_cmd(3'd1, 32'd8, r);
    push(24'h111111); push(24'h222222); push(24'h333333);
    wait_writes(6, 200);
    begin
      int offs[6] = '{0, 2, 4, 6, 0, 2};
      for (int k = 0; k < 6 && k < log_q.size(); k++)
        check("wrap_addr", log_q[k][47:16], 32'h1000 + 32'(offs[k]));
    end
    do_cmd(3'd2, 0, r);
    check("wrap_read_ptr", r, 32'h1004);

    // Stop mode: stops after 4 beats, third sample stays queued.
    log_q.delete();
    do_cmd(3'd5, 32'd1, r);
    do_cmd(3'd1, 32'd8, r);
    push(24'h111111); push(24'h222222); push(24'h345678);
    wait_writes(4, 200);
    repeat (20) tick();
    check("stop_flag", stopped, 1);
    check("stop_write_count", log_q.size(), 4);
    do_cmd(3'd4, 0, r);
    check("stop_fill", r, 1);
    do_cmd(3'd0, 32'h2000, r);
    check("stop_cleared", stopped, 0);
    wait_writes(6, 200);
    if (log_q.size() >= 6) begin
      check("restart_w0", log_q[4], {32'h2000, 16'h5678});
      check("restart_w1", log_q[5], {32'h2002, 16'h0034});
    end
    do_cmd(3'd5, 32'd0, r);

    // Overflow: valid held low, FIFO_DEPTH+2 pushes.
    valid_mode = 0;
    do_cmd(3'd6, 0, r);
    do_cmd(3'd0, 32'h1000, r);
    do_cmd(3'd1, 32'd64, r);
    log_q.delete();
    t0 = cyc;
    for (int i = 0; i < 18; i++) push(24'(i + 1));
    while (cyc - t0 < 5000) tick();
    check("ovf_no_writes", log_q.size(), 0);
    check("ovf_write_stuck", write, 1);
    do_cmd(3'd3, 0, r);
    check("ovf_count", r, 1);
    do_cmd(3'd4, 0, r);
    check("ovf_fill", r, 16);
    do_cmd(3'd6, 0, r);
    check("clear_b0_write", write, 0);
    do_cmd(3'd4, 0, r);
    check("clear_b0_fill", r, 0);
    do_cmd(3'd3, 0, r);
    check("clear_b0_ovf", r, 0);

    // CLEAR during beat 1: write drops on the next cycle, pointer back at base.
    push(24'h00ABCD);
    wait_write_high("b0_write");
    valid_mode = 1;
    tick();
    valid_mode = 0;
    wait_write_high("b1_write");
    check("b1_one_write", log_q.size(), 1);
    cmd = 3'd6; cmd_active = 1'b1;
    tick();
    check("clear_b1_write", write, 0);
    check("clear_b1_ack", cmd_finished, 1);
    cmd_active = 1'b0;
    tick(); tick();
    do_cmd(3'd2, 0, r);
    check("clear_b1_ptr", r, 32'h1000);
    do_cmd(3'd4, 0, r);
    check("clear_b1_fill", r, 0);

    // Asynchronous reset mid-beat.
    push(24'h5A5A5A);
    wait_write_high("rst_write");
    #3;
    rst = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();

    // Randomized stream vs ring-buffer model.
    valid_mode = 2;
    log_q.delete();
    start = 32'h4000 + 32'($urandom_range(0, 255) * 2);
    len   = 32'($urandom_range(0, 20) * 2);
    do_cmd(3'd0, start, r);
    do_cmd(3'd1, len, r);
    for (int i = 0; i < 40; i++) begin
      n = 0;
      while ((rs.size() - log_q.size() / 2) >= 10 && n < 500) begin tick(); n++; end
      rs.push_back(24'($urandom));
      push(rs[i]);
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_writes(80, 3000);
    off_m = 0;
    for (int i = 0; i < 40; i++) begin
      padded = {{8{rs[i][23]}}, rs[i]};
      for (int b = 0; b < 2; b++) begin
        if (2 * i + b < log_q.size())
          check("rand_beat", log_q[2*i+b], {start + off_m, padded[16*b +: 16]});
        off_m = (len != 0 && off_m + 2 >= len) ? 32'd0 : off_m + 2;
      end
    end
    do_cmd(3'd2, 0, r);
    check("rand_ptr", r, start + off_m);
    do_cmd(3'd3, 0, r);
    check("rand_ovf", r, 0);
    do_cmd(3'd7, 32'hFFFF_FFFF, r);
    check("unknown_no_stop", stopped, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
